microsequencer: RTL

Next-state controller for the microprogrammed MIPS control unit. Holds the 7-bit control-state register that addresses the microstore. Each cycle it computes the next state from the next-state fields in the microstore's control word, the instruction opcode, and the datapath condition flags. It also supports memory-wait holding with a timeout and an optional micro-subroutine return stack.

---
 rtl/useq_pkg.sv | 44 ++++
 rtl/ustate_encoder.sv | 29 ++
 rtl/microsequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared types and constants for the microsequencer: next-state select
// codes, condition-mux select codes, the opcode values the decoder
// recognises, and the microstore entry point for each opcode.
package useq_pkg;

    typedef enum logic [2:0] {
        NS_DECODE = 3'd0,
        NS_INC    = 3'd1,
        NS_CJUMP  = 3'd2,
        NS_WAIT   = 3'd3,
        NS_CALL   = 3'd4,
        NS_RET    = 3'd5,
        NS_JUMP   = 3'd6,
        NS_RSVD   = 3'd7
    } ns_sel_e;

    typedef enum logic [2:0] {
        CS_ONE   = 3'd0,
        CS_MOC   = 3'd1,
        CS_ZERO  = 3'd2,
        CS_NEG   = 3'd3,
        CS_CARRY = 3'd4,
        CS_OVF   = 3'd5,
        CS_BR    = 3'd6,
        CS_NEVER = 3'd7
    } cond_sel_e;

    // IR[31:26] values with a dedicated microroutine
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // Microstore entry points for each recognised opcode
    localparam int unsigned ST_RTYPE = 6;
    localparam int unsigned ST_LW    = 7;
    localparam int unsigned ST_SW    = 11;
    localparam int unsigned ST_BEQ   = 12;
    localparam int unsigned ST_ADDI  = 16;
    localparam int unsigned ST_J     = 30;

endpackage

// File: rtl/ustate_encoder.sv
// Opcode to microroutine entry-point map. Unknown opcodes map to state 0
// with o_valid low so the sequencer can flag them.
module ustate_encoder
    import useq_pkg::*;
#(
    parameter int unsigned STATE_W = 7
) (
    input  logic [5:0]         i_opcode,
    output logic [STATE_W-1:0] o_state,
    output logic               o_valid
);

    // Pure lookup; every output gets a default so no latch can form
    always_comb begin
        // NOTE: assigning defaults first in always_comb guarantees every path drives every output, which prevents latch inference.
        o_state = '0;
        o_valid = 1'b1;
        case (i_opcode)
            OP_RTYPE: o_state = STATE_W'(ST_RTYPE);
            OP_LW:    o_state = STATE_W'(ST_LW);
            OP_SW:    o_state = STATE_W'(ST_SW);
            OP_BEQ:   o_state = STATE_W'(ST_BEQ);
            OP_ADDI:  o_state = STATE_W'(ST_ADDI);
            OP_J:     o_state = STATE_W'(ST_J);
            default:  o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Next-state controller for the microprogrammed control unit. Holds the
// control-state register that addresses the microstore and computes the
// next state from the control word, opcode and datapath flags. WAIT holds
// are bounded by MOC_TIMEOUT. Define USEQ_STACK_EN to build the
// micro-subroutine return stack; without it CALL acts as JUMP and RET
// returns to state 0.
module microsequencer
    import useq_pkg::*;
#(
    parameter int unsigned STATE_W     = 7,
    parameter int unsigned MOC_TIMEOUT = 255,
    parameter int unsigned STACK_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ns_sel,
    input  logic [2:0]         cond_sel,
    input  logic               cond_inv,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [5:0]         opcode,
    input  logic               moc,
    input  logic               zero,
    input  logic               negative,
    input  logic               carry,
    input  logic               overflow,
    input  logic               br_cond,
    output logic [STATE_W-1:0] current_state,
    output logic               illegal_op,
    output logic               mem_fault,
    output logic               stack_err
);

    localparam int unsigned CNT_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT + 1) : 1;

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_illegal;
    logic               r_fault;

    logic [STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [STATE_W-1:0] w_inc;
    logic [STATE_W-1:0] w_enc_state;
    logic               w_enc_valid;
    logic               w_cond_raw;
    logic               w_cond;
    logic               w_set_illegal;
    logic               w_set_fault;
    ns_sel_e            w_ns;

    assign w_ns  = ns_sel_e'(ns_sel);
    assign w_inc = r_state + STATE_W'(1);

    ustate_encoder #(.STATE_W(STATE_W)) u_encoder (
        .i_opcode (opcode),
        .o_state  (w_enc_state),
        .o_valid  (w_enc_valid)
    );

    // Condition mux followed by optional inversion
    always_comb begin
        w_cond_raw = 1'b0;
        case (cond_sel_e'(cond_sel))
            CS_ONE:   w_cond_raw = 1'b1;
            CS_MOC:   w_cond_raw = moc;
            CS_ZERO:  w_cond_raw = zero;
            CS_NEG:   w_cond_raw = negative;
            CS_CARRY: w_cond_raw = carry;
            CS_OVF:   w_cond_raw = overflow;
            CS_BR:    w_cond_raw = br_cond;
            default:  w_cond_raw = 1'b0;
        endcase
        w_cond = w_cond_raw ^ cond_inv;
    end

`ifdef USEQ_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [STATE_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]    r_sp;
    logic               r_stack_err;
    logic               w_push;
    logic               w_pop;
    logic               w_set_stack_err;
    logic               w_full;
    logic               w_empty;
    logic [IDX_W-1:0]   w_push_idx;
    logic [IDX_W-1:0]   w_top_idx;

    assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = IDX_W'(r_sp);
    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
`endif

    // Next-state selection, WAIT timeout and fault detection
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = '0;
        w_set_illegal = 1'b0;
        w_set_fault   = 1'b0;
`ifdef USEQ_STACK_EN
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_set_stack_err = 1'b0;
`endif
        case (w_ns)
            NS_DECODE: begin
                w_next_state  = w_enc_state;
                w_set_illegal = !w_enc_valid;
            end
            NS_INC:   w_next_state = w_inc;
            NS_CJUMP: w_next_state = w_cond ? cr_addr : w_inc;
            NS_WAIT: begin
                // A completing memory op wins over a coinciding timeout
                if (w_cond) begin
                    w_next_state = w_inc;
                end else if (r_wait_cnt == CNT_W'(MOC_TIMEOUT)) begin
                    w_next_state = '0;
                    w_set_fault  = 1'b1;
                end else begin
                    w_next_state = r_state;
                    w_next_cnt   = r_wait_cnt + CNT_W'(1);
                end
            end
            NS_CALL: begin
                w_next_state = cr_addr;
`ifdef USEQ_STACK_EN
                if (w_full) w_set_stack_err = 1'b1;
                else        w_push          = 1'b1;
`endif
            end
            NS_RET: begin
                w_next_state = '0;
`ifdef USEQ_STACK_EN
                if (w_empty) begin
                    w_set_stack_err = 1'b1;
                end else begin
                    w_pop        = 1'b1;
                    w_next_state = r_stack[w_top_idx];
                end
`endif
            end
            NS_JUMP:  w_next_state = cr_addr;
            default:  w_next_state = '0;
        endcase
    end

    // State register, WAIT counter and sticky fault flags
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, avoiding order-dependent races.
        if (reset) begin
            r_state    <= '0;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_fault)   r_fault   <= 1'b1;
        end
    end

`ifdef USEQ_STACK_EN
    // Stack pointer and sticky overflow/underflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_push)               r_sp        <= r_sp + SP_W'(1);
            else if (w_pop)           r_sp        <= r_sp - SP_W'(1);
            if (w_set_stack_err)      r_stack_err <= 1'b1;
        end
    end

    // Return-address storage
    always_ff @(posedge clk) begin
        // NOTE: stack storage has no reset; clearing the pointer already discards its contents, so a reset here would only add logic.
        if (w_push) r_stack[w_push_idx] <= w_inc;
    end

    assign stack_err = r_stack_err;
`else
    assign stack_err = 1'b0;
`endif

    assign current_state = r_state;
    assign illegal_op    = r_illegal;
    assign mem_fault     = r_fault;

endmodule
